// File: rtl/sudoku_check_seq.sv
// -----------------------------------------------------------------------------
// sudoku_check_seq
//
// Purpose:
//   Checks the whole Sudoku board when the game FSM asks for it. A request on
//   start (accepted only while idle) walks the 27 constraint groups in a fixed
//   order: 9 rows, then 9 columns, then 9 boxes. Each group issues 9 reads to
//   the synchronous board RAM and tracks which digits it has seen. The block
//   then returns one solved/error verdict.
//
//   Per-group schedule (L = 10 + RD_LAT cycles):
//     ISSUE x9  ->  DRAIN x RD_LAT  ->  EVAL x1
//   After the last group, a single DONE cycle pulses done.
//
// Optional feature:
//   SUDOKU_EARLY_EXIT_EN - when defined, an EVAL that sees any error flag set
//   goes straight to DONE. DRAIN still completes before EVAL, so every cell of
//   the failing group is checked. When undefined, all 27 groups are always
//   checked and the latency is fixed at 27*L+1 cycles.
//
// Parameters:
//   CELL_W  width of one cell value (0 empty, 1-9 digit, 10+ illegal)
//   ADDR_W  board RAM address width (addr = 9*row + col)
//   RD_LAT  board RAM read latency in cycles (1 or 2)
//
// Ports:
//   clka       in   system clock, rising edge
//   restart    in   synchronous active-high reset; overrides start
//   start      in   one-cycle check request, ignored unless idle
//   rd_en      out  board RAM read strobe
//   rd_addr    out  board RAM read address (0 when not reading)
//   rd_data    in   RAM data, valid RD_LAT cycles after rd_en
//   busy       out  high while a check is in progress (not during DONE)
//   done       out  one-cycle completion pulse
//   solved     out  verdict, valid from done until the next start/restart
//   err_dup    out  sticky: a digit was repeated within some group
//   err_empty  out  sticky: some cell read as 0
//   err_range  out  sticky: some cell read above 9
//   grp_idx    out  current group 0-26, 0 when idle
// -----------------------------------------------------------------------------
module sudoku_check_seq #(
   parameter int CELL_W = 4,
   parameter int ADDR_W = 7,
   parameter int RD_LAT = 1
) (
   input  logic              clka,
   input  logic              restart,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [CELL_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              solved,
   output logic              err_dup,
   output logic              err_empty,
   output logic              err_range,
   output logic [4:0]        grp_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_EVAL,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [4:0]        r_grp;        // group 0-26
   logic [3:0]        r_k;          // cell within group 0-8
   logic [1:0]        r_dcnt;       // DRAIN cycle counter
   logic [8:0]        r_seen;       // digits seen in the current group
   logic              r_err_dup;
   logic              r_err_empty;
   logic              r_err_range;
   logic              r_solved;
   logic [RD_LAT-1:0] r_vld;        // rd_en delayed to line up with rd_data

   logic              w_vld;
   logic [8:0]        w_hit;        // one-hot decode of a 1-9 digit
   logic              w_any_err;
   logic [3:0]        w_row;
   logic [3:0]        w_col;
   logic [3:0]        w_box;
   logic [6:0]        w_addr;

   // ------------------------------------------------------------------------
   // Small helpers for box address generation. Operands are only 0-8, so a
   // compare ladder is enough and avoids a general divider.
   // ------------------------------------------------------------------------
   function automatic logic [3:0] div3(input logic [3:0] x);
      if (x >= 4'd6)      div3 = 4'd2;
      else if (x >= 4'd3) div3 = 4'd1;
      else                div3 = 4'd0;
   endfunction

   function automatic logic [3:0] mod3(input logic [3:0] x);
      if (x >= 4'd6)      mod3 = x - 4'd6;
      else if (x >= 4'd3) mod3 = x - 4'd3;
      else                mod3 = x;
   endfunction

   assign w_any_err = r_err_dup | r_err_empty | r_err_range;

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clka) begin
      if (restart) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and control outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      rd_en        = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_ISSUE;
            end
         end

         S_ISSUE: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            if (r_k == 4'd8) begin
               w_state_next = S_DRAIN;
            end
         end

         S_DRAIN: begin
            busy = 1'b1;
            if (r_dcnt == 2'(RD_LAT - 1)) begin
               w_state_next = S_EVAL;
            end
         end

         S_EVAL: begin
            busy = 1'b1;
            if (r_grp == 5'd26) begin
               w_state_next = S_DONE;
`ifdef SUDOKU_EARLY_EXIT_EN
            end else if (w_any_err) begin
               // The failing group's data has fully drained, so its flags
               // are final here; no point walking the remaining groups.
               w_state_next = S_DONE;
`endif
            end else begin
               w_state_next = S_ISSUE;
            end
         end

         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Group / cell / drain counters and verdict
   // ------------------------------------------------------------------------
   always_ff @(posedge clka) begin
      if (restart) begin
         r_grp    <= 5'd0;
         r_k      <= 4'd0;
         r_dcnt   <= 2'd0;
         r_solved <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_grp    <= 5'd0;
                  r_k      <= 4'd0;
                  r_solved <= 1'b0;
               end
            end

            S_ISSUE: begin
               r_dcnt <= 2'd0;
               if (r_k == 4'd8) begin
                  r_k <= 4'd0;
               end else begin
                  r_k <= r_k + 4'd1;
               end
            end

            S_DRAIN: begin
               r_dcnt <= r_dcnt + 2'd1;
            end

            S_EVAL: begin
               r_k <= 4'd0;
               if (w_state_next == S_ISSUE) begin
                  r_grp <= r_grp + 5'd1;
               end
               // No data arrives during EVAL, so the flags are already final
               // when entering DONE; latch the verdict so it shows with done.
               if (w_state_next == S_DONE) begin
                  r_solved <= ~w_any_err;
               end
            end

            S_DONE: begin
               r_grp <= 5'd0;
            end

            default: begin
               r_grp <= 5'd0;
               r_k   <= 4'd0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Read-valid delay line: marks the cycles on which rd_data belongs to one
   // of our reads. Cleared on restart so in-flight data is discarded.
   // ------------------------------------------------------------------------
   generate
      if (RD_LAT == 1) begin : g_lat1
         always_ff @(posedge clka) begin
            if (restart) begin
               r_vld <= '0;
            end else begin
               r_vld <= rd_en;
            end
         end
      end else begin : g_latn
         always_ff @(posedge clka) begin
            if (restart) begin
               r_vld <= '0;
            end else begin
               r_vld <= {r_vld[RD_LAT-2:0], rd_en};
            end
         end
      end
   endgenerate

   assign w_vld = r_vld[RD_LAT-1];

   // ------------------------------------------------------------------------
   // Digit decode: w_hit[d-1] is set when rd_data equals digit d.
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 9; gi++) begin : g_hit
         assign w_hit[gi] = (rd_data == CELL_W'(gi + 1));
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Cell classification and sticky error flags
   // ------------------------------------------------------------------------
   always_ff @(posedge clka) begin
      if (restart) begin
         r_seen      <= 9'd0;
         r_err_dup   <= 1'b0;
         r_err_empty <= 1'b0;
         r_err_range <= 1'b0;
      end else if (r_state == S_IDLE && start) begin
         r_seen      <= 9'd0;
         r_err_dup   <= 1'b0;
         r_err_empty <= 1'b0;
         r_err_range <= 1'b0;
      end else if (r_state == S_EVAL) begin
         r_seen <= 9'd0;
      end else if (w_vld) begin
         if (rd_data == '0) begin
            r_err_empty <= 1'b1;
         end
         if (rd_data > CELL_W'(9)) begin
            r_err_range <= 1'b1;
         end
         // w_hit is zero for 0 and out-of-range values, so they never
         // touch the seen mask.
         if ((w_hit & r_seen) != 9'd0) begin
            r_err_dup <= 1'b1;
         end
         r_seen <= r_seen | w_hit;
      end
   end

   // ------------------------------------------------------------------------
   // Address generation for (group, k)
   // ------------------------------------------------------------------------
   always_comb begin
      w_row = 4'd0;
      w_col = 4'd0;
      w_box = 4'd0;
      if (r_grp < 5'd9) begin
         w_row = r_grp[3:0];
         w_col = r_k;
      end else if (r_grp < 5'd18) begin
         w_row = r_k;
         w_col = 4'(r_grp - 5'd9);
      end else begin
         w_box = 4'(r_grp - 5'd18);
         w_row = div3(w_box) * 4'd3 + div3(r_k);
         w_col = mod3(w_box) * 4'd3 + mod3(r_k);
      end
   end

   assign w_addr = {3'b000, w_row} * 7'd9 + {3'b000, w_col};

   assign rd_addr   = (r_state == S_ISSUE) ? ADDR_W'(w_addr) : '0;
   assign solved    = r_solved;
   assign err_dup   = r_err_dup;
   assign err_empty = r_err_empty;
   assign err_range = r_err_range;
   assign grp_idx   = r_grp;

endmodule

// File: tb/tb_sudoku_check_seq.sv
// -----------------------------------------------------------------------------
// tb_sudoku_check_seq
//
// Bench for sudoku_check_seq with a board RAM model. Directed cases come from
// a table, plus hand-written restart and busy-start sequences and random
// boards. Expected read order, flags and completion cycle for random boards
// come from a reference model that works directly on rows, columns and boxes
// of the board.
// -----------------------------------------------------------------------------
module tb_sudoku_check_seq;

   localparam int TB_LAT = 1;
   localparam int L      = 10 + TB_LAT;

   logic       clka = 1'b0;
   logic       restart;
   logic       start;
   logic       rd_en;
   logic [6:0] rd_addr;
   logic [3:0] rd_data;
   logic       busy;
   logic       done;
   logic       solved;
   logic       err_dup;
   logic       err_empty;
   logic       err_range;
   logic [4:0] grp_idx;

   always #5 clka = ~clka;

   sudoku_check_seq #(
      .CELL_W (4),
      .ADDR_W (7),
      .RD_LAT (TB_LAT)
   ) dut (
      .clka      (clka),
      .restart   (restart),
      .start     (start),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done),
      .solved    (solved),
      .err_dup   (err_dup),
      .err_empty (err_empty),
      .err_range (err_range),
      .grp_idx   (grp_idx)
   );

   // Board RAM: synchronous read with TB_LAT cycles of latency. Non-read
   // cycles return 15 so that sampling at the wrong time shows up as err_range.
   logic [3:0] mem  [81];
   logic [3:0] pipe [TB_LAT];

   always @(posedge clka) begin
      pipe[0] <= (rd_en && rd_addr < 7'd81) ? mem[rd_addr] : 4'hF;
      for (int i = 1; i < TB_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign rd_data = pipe[TB_LAT-1];

   int n_checks = 0;
   int n_pass   = 0;
   int exp_q[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // Standard valid board: row r is 1..9 rotated by 3r + r/3.
   task automatic load_base();
      for (int a = 0; a < 81; a++) begin
         int r, c;
         r = a / 9;
         c = a % 9;
         mem[a] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
      end
   endtask

   task automatic swap_cells(input int a, input int b);
      logic [3:0] t;
      t      = mem[a];
      mem[a] = mem[b];
      mem[b] = t;
   endtask

   // Reference model: for each group in order, collect its cells by scanning
   // the board in ascending address order, classify the values, and decide
   // the final flags and completion cycle.
   task automatic model(output bit s, output bit d, output bit e, output bit r,
                        output int done_cyc);
      int last;
      exp_q.delete();
      d = 0; e = 0; r = 0;
      last = 26;
      for (int g = 0; g < 27; g++) begin
         int cnt[10];
         bit stop;
         for (int v = 0; v < 10; v++) cnt[v] = 0;
         for (int a = 0; a < 81; a++) begin
            int rr, cc, v;
            bit in_grp;
            rr = a / 9;
            cc = a % 9;
            if (g < 9)       in_grp = (rr == g);
            else if (g < 18) in_grp = (cc == g - 9);
            else             in_grp = ((rr / 3) * 3 + cc / 3 == g - 18);
            if (in_grp) begin
               exp_q.push_back(a);
               v = int'(mem[a]);
               if (v == 0)     e = 1;
               else if (v > 9) r = 1;
               else begin
                  if (cnt[v] > 0) d = 1;
                  cnt[v]++;
               end
            end
         end
         stop = 0;
`ifdef SUDOKU_EARLY_EXIT_EN
         if (d || e || r) stop = 1;
`endif
         if (stop) begin
            last = g;
            break;
         end
      end
      s = !(d || e || r);
      done_cyc = (last + 1) * L + 1;
   endtask

   // Run one full check and compare the cycle-by-cycle trace and the verdict.
   // poke_cyc > 0 pulses start during that cycle (must be ignored).
   task automatic run_check(input string nm, input bit es, input bit ed,
                            input bit ee, input bit er, input int exp_done,
                            input int poke_cyc);
      int  done_at;
      int  trace_err;
      bit  seen_done;
      int  cyc;
      @(posedge clka); #1 start = 1'b1;
      @(posedge clka); #1 start = 1'b0;
      seen_done = 0;
      trace_err = 0;
      done_at   = -1;
      for (cyc = 1; cyc <= 400 && !seen_done; cyc++) begin
         bit exp_rd;
         @(negedge clka);
         if (cyc == 1)
            chk({nm, ":clear_on_start"}, int'({solved, err_dup, err_empty, err_range}), 0);
         if (busy !== (cyc < exp_done)) begin
            if (trace_err == 0) $display("  %s: busy=%0d at cycle %0d", nm, busy, cyc);
            trace_err++;
         end
         if (cyc < exp_done && int'(grp_idx) != (cyc - 1) / L) begin
            if (trace_err == 0) $display("  %s: grp_idx=%0d at cycle %0d", nm, grp_idx, cyc);
            trace_err++;
         end
         exp_rd = (cyc < exp_done) && (((cyc - 1) % L) < 9);
         if (rd_en !== exp_rd) begin
            if (trace_err == 0) $display("  %s: rd_en=%0d at cycle %0d", nm, rd_en, cyc);
            trace_err++;
         end
         if (rd_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               trace_err++;
            end else begin
               int ea;
               ea = exp_q.pop_front();
               if (int'(rd_addr) != ea) begin
                  if (trace_err == 0)
                     $display("  %s: rd_addr=%0d want %0d at cycle %0d", nm, rd_addr, ea, cyc);
                  trace_err++;
               end
            end
         end
         if (done === 1'b1) begin
            seen_done = 1;
            done_at   = cyc;
         end
         start = (cyc == poke_cyc);
      end
      chk({nm, ":done_seen"}, int'(seen_done), 1);
      chk({nm, ":done_cycle"}, done_at, exp_done);
      chk({nm, ":solved"}, int'(solved), int'(es));
      chk({nm, ":flags_dup_empty_range"}, int'({err_dup, err_empty, err_range}),
          int'({ed, ee, er}));
      chk({nm, ":trace_errors"}, trace_err, 0);
      chk({nm, ":reads_left"}, exp_q.size(), 0);
      @(negedge clka);
      start = 1'b0;
      chk({nm, ":after_done_idle"}, int'({done, busy, rd_en, grp_idx}), 0);
      chk({nm, ":solved_held"}, int'(solved), int'(es));
      $display("run %s: done at cycle %0d solved=%0d dup=%0d empty=%0d range=%0d",
               nm, done_at, solved, err_dup, err_empty, err_range);
   endtask

   typedef struct {
      string name;
      int    mut;
      int    poke;      // 0 none, >0 cycle, -1 the DONE cycle
      bit    s, d, e, r;
      int    done_def;
      int    done_ee;
   } vec_t;

   vec_t tbl[5];

   initial begin
      bit ms, md, me, mr;
      int mdc;

      tbl[0] = '{"valid",    0, 100, 1'b1, 1'b0, 1'b0, 1'b0, 298, 298};
      tbl[1] = '{"empty40",  1,   0, 1'b0, 1'b0, 1'b1, 1'b0, 298,  56};
      tbl[2] = '{"dupcol",   2,   0, 1'b0, 1'b1, 1'b0, 1'b0, 298, 111};
      tbl[3] = '{"range80",  3,  -1, 1'b0, 1'b0, 1'b0, 1'b1, 298, 100};
      tbl[4] = '{"duprow0",  4,   0, 1'b0, 1'b1, 1'b0, 1'b0, 298,  12};

      restart = 1'b1;
      start   = 1'b0;
      load_base();
      repeat (3) @(posedge clka);
      @(negedge clka);
      chk("reset:ctl", int'({rd_en, busy, done, solved}), 0);
      chk("reset:err", int'({err_dup, err_empty, err_range}), 0);
      chk("reset:addr_grp", int'({rd_addr, grp_idx}), 0);
      restart = 1'b0;
      repeat (2) @(negedge clka);
      chk("idle_no_start", int'({busy, rd_en, done}), 0);

      foreach (tbl[i]) begin
         int ed, pk;
         load_base();
         case (tbl[i].mut)
            1: mem[40] = 4'd0;
            2: begin swap_cells(0, 1); swap_cells(9, 10); end
            3: mem[80] = 4'd12;
            4: mem[1] = mem[0];
            default: ;
         endcase
         model(ms, md, me, mr, mdc);   // builds the expected read sequence
`ifdef SUDOKU_EARLY_EXIT_EN
         ed = tbl[i].done_ee;
`else
         ed = tbl[i].done_def;
`endif
         pk = (tbl[i].poke < 0) ? ed : tbl[i].poke;
         run_check(tbl[i].name, tbl[i].s, tbl[i].d, tbl[i].e, tbl[i].r, ed, pk);
      end

      // Restart mid-check (group 5) with start held in the same cycle.
      load_base();
      @(posedge clka); #1 start = 1'b1;
      @(posedge clka); #1 start = 1'b0;
      repeat (59) @(posedge clka);
      @(negedge clka);
      chk("restart:grp_before", int'(grp_idx), 5);
      restart = 1'b1;
      start   = 1'b1;
      @(negedge clka);
      restart = 1'b0;
      start   = 1'b0;
      chk("restart:next_cycle", int'({busy, rd_en, done, grp_idx, rd_addr}), 0);
      @(negedge clka);
      chk("restart:start_overridden", int'({busy, rd_en}), 0);
      model(ms, md, me, mr, mdc);
      run_check("after_restart", ms, md, me, mr, mdc, 0);

      // Random boards checked against the reference model.
      for (int n = 0; n < 8; n++) begin
         load_base();
         case ($urandom_range(0, 3))
            1: mem[$urandom_range(0, 80)] = 4'($urandom_range(0, 15));
            2: swap_cells($urandom_range(0, 80), $urandom_range(0, 80));
            3: for (int j = 0; j < 3; j++)
                  mem[$urandom_range(0, 80)] = 4'($urandom_range(0, 15));
            default: ;
         endcase
         model(ms, md, me, mr, mdc);
         run_check($sformatf("rand%0d", n), ms, md, me, mr, mdc, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
